rt_irq_controller: RTL

- Consumer end of the peripheral interrupt lines, e.g. the 4 timer_irq outputs of the RT timer bank plus other peripheral IRQs.
- Latches, masks and prioritises up to NUM_SRC sources and presents one request at a time to a core over a req/ack handshake.
- Service ends when software writes EOI; nesting is not supported.
- Software-configured through the same word-addressed register interface as the other peripherals, with a registered read.

---
 rtl/rt_irq_controller.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rt_irq_controller.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rt_irq_controller
//
// Purpose:
//   Collects up to NUM_SRC peripheral interrupt lines, latches them into a
//   pending register (edge or level per source), masks them with ENABLE and
//   presents the highest-priority (lowest index) source to the core over a
//   req/ack handshake. Service ends when software writes EOI. No nesting.
//
// Optional feature (macro RT_IRQ_LATENCY_EN):
//   Defined   -> a saturating 32-bit counter measures REQ cycles before ack
//                and the count is captured in the read-only LATENCY register.
//   Undefined -> no counter logic; LATENCY reads 0.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   reg_en      register access strobe
//   reg_we      1 = write, 0 = read
//   reg_addr    word register index
//   reg_wdata   write data
//   reg_rdata   registered read data, valid the cycle after a read strobe
//   irq_src     interrupt lines, synchronous to clk
//   irq_req     interrupt request to core
//   irq_id      ID of the requested/active source (stable while irq_req=1)
//   irq_ack     core accepts the request (only honoured in REQ)
//   in_service  high from ack until EOI
//
// Handshake: irq_req/irq_id are held from the IDLE->REQ edge until either
//   the core asserts irq_ack in a cycle where irq_req=1 (transfer happens on
//   that clock edge) or the request is withdrawn because its pending or
//   enable bit reads 0. An ack in the same cycle as a withdrawal wins.
//
// Register map (reg_addr):
//   0 PEND (R, W1C)  1 ENABLE (RW)  2 TRIGGER (RW, 1=edge)  3 SOFTSET (W1S)
//   4 ACTIVE (R)     5 EOI (W)      6 STATUS (R)            7 LATENCY (R)
// ---------------------------------------------------------------------------
module rt_irq_controller #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reg_en,
    input  logic               reg_we,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    output logic               in_service
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] A_PEND    = 4'd0;
    localparam logic [3:0] A_ENABLE  = 4'd1;
    localparam logic [3:0] A_TRIGGER = 4'd2;
    localparam logic [3:0] A_SOFTSET = 4'd3;
    localparam logic [3:0] A_ACTIVE  = 4'd4;
    localparam logic [3:0] A_EOI     = 4'd5;
    localparam logic [3:0] A_STATUS  = 4'd6;
    localparam logic [3:0] A_LATENCY = 4'd7;

    // Registers
    state_t             r_state;
    logic [ID_W-1:0]    r_id;
    logic               r_irq_req;
    logic               r_in_service;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_trigger;
    logic [31:0]        r_rdata;

    // Combinational helpers
    logic               w_wr;
    logic               w_rd;
    logic               w_eoi;
    logic               w_ack;
    logic               w_any;
    logic               w_withdraw;
    logic [NUM_SRC-1:0] w_wdata_src;
    logic [NUM_SRC-1:0] w_masked;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [ID_W-1:0]    w_next_id;
    logic [31:0]        w_rdata_next;

    assign w_wr        = reg_en & reg_we;
    assign w_rd        = reg_en & ~reg_we;
    assign w_eoi       = w_wr && (reg_addr == A_EOI);
    assign w_wdata_src = reg_wdata[NUM_SRC-1:0];
    assign w_masked    = r_pending & r_enable;
    assign w_any       = |w_masked;
    assign w_ack       = irq_ack && (r_state == S_REQ);
    // A request is withdrawn when its own source is no longer pending+enabled.
    assign w_withdraw  = ~r_pending[r_id] | ~r_enable[r_id];

    // High write-data bits above NUM_SRC carry no meaning.
    if (NUM_SRC < 32) begin : g_wdata_pad
        logic w_unused_wdata;
        assign w_unused_wdata = ^reg_wdata[31:NUM_SRC];
    end

    // Fixed priority: lowest index wins, so scan downward and let the last
    // hit (the smallest index) stick.
    always_comb begin
        w_next_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_next_id = ID_W'(i);
            end
        end
    end

    // Pending update: sets (edge, level, SOFTSET) take priority over clears
    // (W1C or ack) landing in the same cycle.
    always_comb begin
        w_set = (r_trigger & irq_src & ~r_src_q) | (~r_trigger & irq_src);
        if (w_wr && (reg_addr == A_SOFTSET)) begin
            w_set = w_set | w_wdata_src;
        end
    end

    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_clr[i] = w_ack && (r_id == ID_W'(i));
        end
    end

    always_comb begin
        w_clr = w_ack_clr;
        if (w_wr && (reg_addr == A_PEND)) begin
            w_clr = w_clr | w_wdata_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_q   <= '0;
            r_pending <= '0;
        end else begin
            r_src_q   <= irq_src;
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable  <= '0;
            r_trigger <= '0;
        end else if (w_wr) begin
            if (reg_addr == A_ENABLE) begin
                r_enable <= w_wdata_src;
            end
            if (reg_addr == A_TRIGGER) begin
                r_trigger <= w_wdata_src;
            end
        end
    end

    // Request/service FSM. irq_req and in_service are registered alongside
    // the state so they change exactly on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_id         <= '0;
            r_irq_req    <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id      <= w_next_id;
                        r_state   <= S_REQ;
                        r_irq_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    // irq_id is frozen here; re-arbitration only in IDLE.
                    if (irq_ack) begin
                        r_state      <= S_SERVICE;
                        r_irq_req    <= 1'b0;
                        r_in_service <= 1'b1;
                    end else if (w_withdraw) begin
                        r_state   <= S_IDLE;
                        r_irq_req <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (w_eoi) begin
                        r_state      <= S_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_irq_req    <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

`ifdef RT_IRQ_LATENCY_EN
    logic [31:0] r_lat_cnt;
    logic [31:0] r_latency;

    // Counter restarts on entry to REQ and counts REQ cycles; the value seen
    // on the ack edge is the number of cycles the request waited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= '0;
            r_latency <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any) begin
                r_lat_cnt <= '0;
            end else if ((r_state == S_REQ) && (r_lat_cnt != 32'hFFFF_FFFF)) begin
                r_lat_cnt <= r_lat_cnt + 32'd1;
            end
            if (w_ack) begin
                r_latency <= r_lat_cnt;
            end
        end
    end
`endif

    // Read mux works on the pre-update register values.
    always_comb begin
        w_rdata_next = '0;
        case (reg_addr)
            A_PEND:    w_rdata_next[NUM_SRC-1:0] = r_pending;
            A_ENABLE:  w_rdata_next[NUM_SRC-1:0] = r_enable;
            A_TRIGGER: w_rdata_next[NUM_SRC-1:0] = r_trigger;
            A_ACTIVE: begin
                w_rdata_next[31]       = r_in_service;
                w_rdata_next[ID_W-1:0] = r_id;
            end
            A_STATUS:  w_rdata_next[1:0] = r_state;
`ifdef RT_IRQ_LATENCY_EN
            A_LATENCY: w_rdata_next = r_latency;
`endif
            default:   w_rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rdata_next;
        end
    end

    assign reg_rdata  = r_rdata;
    assign irq_req    = r_irq_req;
    assign irq_id     = r_id;
    assign in_service = r_in_service;

endmodule
